pellet_tracker: RTL and testbench

Sits directly downstream of the pacman movement block. It consumes pacman's pixel position once per frame and keeps a per-tile pellet bitmap. When pacman reaches a tile centre that holds a pellet, the block clears that pellet, adds to the score and counts down the pellets remaining. It also serves pellet-present lookups to the sprite/maze renderer and builds its bitmap at start of level by querying the wall detector tile by tile.

---
 rtl/pellet_tracker.sv | 166 ++++++++++++++++
 tb/tb_pellet_tracker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pellet_tracker.sv
// Per-tile pellet bitmap for the maze: built from the wall detector at level start,
// cleared as pacman crosses tile centres, and read back by the renderer.
module pellet_tracker #(
    parameter int unsigned GRID_W     = 40,
    parameter int unsigned GRID_H     = 30,
    parameter int unsigned PELLET_PTS = 10,
    parameter int unsigned SCORE_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [9:0]         pac_x,
    input  logic [9:0]         pac_y,
    input  logic               ggShow,
    input  logic               restart,
    output logic [5:0]         wall_q_col,
    output logic [4:0]         wall_q_row,
    input  logic               wall_q_hit,
    input  logic [5:0]         rd_col,
    input  logic [4:0]         rd_row,
    output logic               rd_pellet,
    output logic [SCORE_W-1:0] score,
    output logic [10:0]        pellets_left,
    output logic               eat_pulse,
    output logic               ready,
    output logic               level_clear
);

    localparam int unsigned NTILES   = GRID_W * GRID_H;
    localparam logic [10:0] LAST_IDX = 11'(NTILES - 1);
    localparam logic [5:0]  LAST_COL = 6'(GRID_W - 1);
    localparam logic [5:0]  GRID_W_T = 6'(GRID_W);
    localparam logic [5:0]  GRID_H_T = 6'(GRID_H);
    localparam logic [10:0] GRID_W_I = 11'(GRID_W);

    typedef enum logic [1:0] {StInit, StRun, StCleared} state_t;

    state_t              state_q;
    logic [10:0]         idx_q;
    logic [5:0]          col_q;
    logic [4:0]          row_q;
    logic [NTILES-1:0]   bitmap_q;
    logic [SCORE_W-1:0]  score_q;
    logic [10:0]         pellets_left_q;
    logic                eat_pulse_q;
    logic                rd_pellet_q;
    logic                ready_q;
    logic                level_clear_q;
    logic                fc_meta_q, fc_sync_q, fc_prev_q;

    logic                frame_tick;
    logic [5:0]          pac_tx, pac_ty;
    logic                pac_centre, pac_in_grid;
    logic [10:0]         pac_idx, rd_idx;
    logic                rd_in_grid;
    logic                eat;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  score_next;

    assign frame_tick  = fc_sync_q & ~fc_prev_q;

    assign pac_tx      = pac_x[9:4];
    assign pac_ty      = pac_y[9:4];
    assign pac_centre  = (pac_x[3:0] == 4'd8) && (pac_y[3:0] == 4'd8);
    assign pac_in_grid = (pac_tx < GRID_W_T) && (pac_ty < GRID_H_T);
    // Gate the index so an out-of-grid position never addresses past the bitmap
    assign pac_idx     = pac_in_grid ? (11'(pac_ty) * GRID_W_I + 11'(pac_tx)) : 11'd0;

    assign rd_in_grid  = (rd_col < GRID_W_T) && ({1'b0, rd_row} < GRID_H_T);
    assign rd_idx      = rd_in_grid ? (11'(rd_row) * GRID_W_I + 11'(rd_col)) : 11'd0;

    assign eat = (state_q == StRun) && frame_tick && !ggShow && pac_centre && pac_in_grid
                 && bitmap_q[pac_idx];

    assign score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(PELLET_PTS);
    assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= StInit;
            idx_q          <= '0;
            col_q          <= '0;
            row_q          <= '0;
            bitmap_q       <= '0;
            score_q        <= '0;
            pellets_left_q <= '0;
            eat_pulse_q    <= 1'b0;
            rd_pellet_q    <= 1'b0;
            ready_q        <= 1'b0;
            level_clear_q  <= 1'b0;
            fc_meta_q      <= 1'b0;
            fc_sync_q      <= 1'b0;
            fc_prev_q      <= 1'b0;
        end else begin
            fc_meta_q   <= frame_clk;
            fc_sync_q   <= fc_meta_q;
            fc_prev_q   <= fc_sync_q;
            eat_pulse_q <= 1'b0;
            // Reads the pre-update bitmap, so a same-cycle eat still returns 1
            rd_pellet_q <= rd_in_grid ? bitmap_q[rd_idx] : 1'b0;

            if (restart) begin
                state_q        <= StInit;
                idx_q          <= '0;
                col_q          <= '0;
                row_q          <= '0;
                bitmap_q       <= '0;
                score_q        <= '0;
                pellets_left_q <= '0;
                ready_q        <= 1'b0;
                level_clear_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StInit: begin
                        bitmap_q[idx_q] <= ~wall_q_hit;
                        if (!wall_q_hit) begin
                            pellets_left_q <= pellets_left_q + 11'd1;
                        end
                        if (idx_q == LAST_IDX) begin
                            // Counters return to 0 so the wall query port idles at tile 0
                            idx_q   <= '0;
                            col_q   <= '0;
                            row_q   <= '0;
                            state_q <= StRun;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 11'd1;
                            if (col_q == LAST_COL) begin
                                col_q <= '0;
                                row_q <= row_q + 5'd1;
                            end else begin
                                col_q <= col_q + 6'd1;
                            end
                        end
                    end
                    StRun: begin
                        if (pellets_left_q == 11'd0) begin
                            state_q       <= StCleared;
                            level_clear_q <= 1'b1;
                        end else if (eat) begin
                            bitmap_q[pac_idx] <= 1'b0;
                            score_q           <= score_next;
                            pellets_left_q    <= pellets_left_q - 11'd1;
                            eat_pulse_q       <= 1'b1;
                        end
                    end
                    StCleared: begin
                    end
                    default: begin
                        state_q <= StInit;
                    end
                endcase
            end
        end
    end

    assign wall_q_col   = col_q;
    assign wall_q_row   = row_q;
    assign rd_pellet    = rd_pellet_q;
    assign score        = score_q;
    assign pellets_left = pellets_left_q;
    assign eat_pulse    = eat_pulse_q;
    assign ready        = ready_q;
    assign level_clear  = level_clear_q;

endmodule

// File: tb/tb_pellet_tracker.sv
// Scoreboarded bench for pellet_tracker: a default instance plus one with a large
// per-pellet score to exercise saturation under the same stimulus.
module tb_pellet_tracker;

    logic        Clk = 1'b0;
    logic        Reset, frame_clk, ggShow, restart;
    logic [9:0]  pac_x, pac_y;
    logic [5:0]  rd_col;
    logic [4:0]  rd_row;
    logic [5:0]  wq_col, wq_col_s;
    logic [4:0]  wq_row, wq_row_s;
    logic        wq_hit, wq_hit_s;
    logic        rd_pellet, rd_pellet_s;
    logic [15:0] score, score_s;
    logic [10:0] pellets_left, pellets_left_s;
    logic        eat_pulse, eat_pulse_s, ready, ready_s, level_clear, level_clear_s;

    int          wall_mode;
    int          total = 0;
    int          bad   = 0;
    int          eats_seen = 0;
    int          eats_exp  = 0;
    logic        prev_eat  = 1'b0;

    typedef struct {
        logic [15:0] score;
        logic [15:0] score_sat;
        logic [10:0] left;
    } exp_t;
    exp_t exp_q[$];

    always #5 Clk = ~Clk;

    pellet_tracker dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pac_x(pac_x), .pac_y(pac_y),
        .ggShow(ggShow), .restart(restart), .wall_q_col(wq_col), .wall_q_row(wq_row),
        .wall_q_hit(wq_hit), .rd_col(rd_col), .rd_row(rd_row), .rd_pellet(rd_pellet),
        .score(score), .pellets_left(pellets_left), .eat_pulse(eat_pulse), .ready(ready),
        .level_clear(level_clear)
    );

    pellet_tracker #(.PELLET_PTS(32'h7FFF)) dut_sat (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pac_x(pac_x), .pac_y(pac_y),
        .ggShow(ggShow), .restart(restart), .wall_q_col(wq_col_s), .wall_q_row(wq_row_s),
        .wall_q_hit(wq_hit_s), .rd_col(rd_col), .rd_row(rd_row), .rd_pellet(rd_pellet_s),
        .score(score_s), .pellets_left(pellets_left_s), .eat_pulse(eat_pulse_s),
        .ready(ready_s), .level_clear(level_clear_s)
    );

    // Mode 0: only row 0 is wall. Mode 1: everything is wall except tile (2,3).
    function automatic logic wall_at(input int mode, input logic [5:0] c, input logic [4:0] r);
        if (mode == 0) return (r == 5'd0);
        return !((c == 6'd2) && (r == 5'd3));
    endfunction

    always_comb begin
        wq_hit   = wall_at(wall_mode, wq_col, wq_row);
        wq_hit_s = wall_at(wall_mode, wq_col_s, wq_row_s);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && eat_pulse) begin
            exp_t e;
            eats_seen++;
            chk("eat_width", {31'd0, prev_eat}, 32'd0);
            chk("eat_pre_clear_read", {31'd0, rd_pellet}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("eat_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("eat_score", {16'd0, score}, {16'd0, e.score});
                chk("eat_score_sat", {16'd0, score_s}, {16'd0, e.score_sat});
                chk("eat_left", {21'd0, pellets_left}, {21'd0, e.left});
            end
        end
        prev_eat = eat_pulse;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        tick(5);
        frame_clk = 1'b0;
        tick(5);
    endtask

    task automatic read_chk(input string tag, input int c, input int r, input logic want);
        rd_col = 6'(c);
        rd_row = 5'(r);
        tick(1);
        chk(tag, {31'd0, rd_pellet}, {31'd0, want});
    endtask

    task automatic do_eat(input int tx, input int ty, input logic [15:0] s,
                          input logic [15:0] ss, input logic [10:0] left);
        exp_t e;
        e.score = s; e.score_sat = ss; e.left = left;
        exp_q.push_back(e);
        eats_exp++;
        pac_x  = 10'(tx * 16 + 8);
        pac_y  = 10'(ty * 16 + 8);
        rd_col = 6'(tx);
        rd_row = 5'(ty);
        frame();
    endtask

    task automatic wait_ready(input string tag);
        int cnt = 0;
        while (!ready && cnt < 2000) begin
            tick(1);
            cnt++;
            if (cnt == 45) begin
                chk("scan_col", {26'd0, wq_col}, 32'd5);
                chk("scan_row", {27'd0, wq_row}, 32'd1);
            end
        end
        chk(tag, cnt, 1200);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; ggShow = 1'b0; restart = 1'b0;
        pac_x = '0; pac_y = '0; rd_col = '0; rd_row = '0; wall_mode = 0;
        tick(3);
        Reset = 1'b0;
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_left", {21'd0, pellets_left}, 0);
        chk("rst_score", {16'd0, score}, 0);
        chk("rst_clear", {31'd0, level_clear}, 0);
        chk("rst_eat", {31'd0, eat_pulse}, 0);
        chk("rst_rd", {31'd0, rd_pellet}, 0);

        wait_ready("init_cycles");
        chk("init_left", {21'd0, pellets_left}, 1160);
        read_chk("rd_wall_5_0", 5, 0, 1'b0);
        read_chk("rd_pellet_5_1", 5, 1, 1'b1);
        read_chk("rd_oob_col", 40, 1, 1'b0);
        read_chk("rd_oob_row", 3, 30, 1'b0);
        read_chk("rd_last", 39, 29, 1'b1);

        do_eat(8, 14, 16'd10, 16'h7FFF, 11'd1159);
        read_chk("rd_eaten", 8, 14, 1'b0);
        frame();
        chk("reeat_score", {16'd0, score}, 10);
        chk("reeat_left", {21'd0, pellets_left}, 1159);

        pac_x = 10'h085; pac_y = 10'h0E8;
        repeat (3) frame();
        ggShow = 1'b1; pac_x = 10'h0A8;
        frame();
        ggShow = 1'b0; pac_x = 10'h288;
        frame();
        chk("noeat_score", {16'd0, score}, 10);
        chk("noeat_count", eats_seen, 1);

        do_eat(10, 14, 16'd20, 16'hFFFE, 11'd1158);
        do_eat(12, 14, 16'd30, 16'hFFFF, 11'd1157);
        chk("sat_final", {16'd0, score_s}, 32'hFFFF);

        wall_mode = 1;
        pulse_restart();
        chk("rst1_score", {16'd0, score}, 0);
        chk("rst1_ready", {31'd0, ready}, 0);
        tick(599);
        pulse_restart();
        wait_ready("restart_mid_init");
        chk("one_left", {21'd0, pellets_left}, 1);
        chk("one_score", {16'd0, score}, 0);

        begin
            exp_t e;
            int   cnt = 0;
            e.score = 16'd10; e.score_sat = 16'h7FFF; e.left = 11'd0;
            exp_q.push_back(e);
            eats_exp++;
            pac_x = 10'h028; pac_y = 10'h038; rd_col = 6'd2; rd_row = 5'd3;
            frame_clk = 1'b1;
            while (!eat_pulse && cnt < 10) begin
                tick(1);
                cnt++;
            end
            chk("clear_eat_seen", {31'd0, eat_pulse}, 1);
            chk("clear_not_yet", {31'd0, level_clear}, 0);
            tick(1);
            chk("clear_set", {31'd0, level_clear}, 1);
            frame_clk = 1'b0;
            tick(5);
        end
        repeat (2) frame();
        chk("cleared_hold", {31'd0, level_clear}, 1);
        chk("cleared_ready", {31'd0, ready}, 1);
        chk("cleared_score", {16'd0, score}, 10);

        pulse_restart();
        chk("rst2_clear", {31'd0, level_clear}, 0);
        chk("rst2_score", {16'd0, score}, 0);
        wait_ready("restart_after_clear");
        chk("rst2_left", {21'd0, pellets_left}, 1);

        tick(5);
        chk("eat_q_empty", exp_q.size(), 0);
        chk("eat_count", eats_seen, eats_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
